mdio_responder: RTL
===================

Name: mdio_responder

Overview:
- Clause-22 MDIO management responder (PHY side) for the Hermes-Lite FPGA. It answers read and write frames from the core's MDIO master (PHY_MDC/PHY_MDIO) out of a local 16-bit register file.
- Used to emulate PHY management registers, and as the loopback target for bench tests of the core's MDIO initiator.
- MDC is oversampled in the system clock domain; the block contains no MDC-clocked logic.

Parameters:
- PHYADDR, 5'd1, PHY address this block answers to.
- NREG, 16, number of implemented registers (1..32); addresses >= NREG are unimplemented.
- ID1, 16'h0022, reset value of register 2.
- ID2, 16'h1560, reset value of register 3.
- PRE_LEN, 32, minimum count of consecutive preamble ones.

Ports:
- clk  in  1  system clock; must be >= 4x MDC frequency.
- rst  in  1  synchronous, active-high reset.
- mdc  in  1  MDIO clock from the master (asynchronous).
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO pad output enable (1 = drive).
- host_we  in  1  local register write strobe.
- host_addr  in  5  local write address.
- host_data  in  16  local write data.
- wr_strobe  out  1  one-cycle pulse when an MDIO write commits.
- wr_addr  out  5  register address of the committed MDIO write.
- wr_data  out  16  data of the committed MDIO write.

Behaviour:
- Input capture: mdc and mdio_i each pass through a 2-flop synchronizer.
- Edges: rise = mdc_s & ~mdc_d; fall = ~mdc_s & mdc_d.
- Bit sampling: mdio_s is sampled on rise only.
- Reset values: all outputs 0 (mdio_oe=0, mdio_o=0, wr_strobe=0, wr_addr=0, wr_data=0); registers 0; reg2=ID1; reg3=ID2; FSM in IDLE; preamble counter 0.
- IDLE:
  - A sampled 1 increments the preamble counter, saturating at PRE_LEN.
  - A sampled 0 with counter == PRE_LEN goes to ST2. The 0 is the first ST bit.
  - A sampled 0 with counter < PRE_LEN clears the counter.
- ST2: sampled 1 -> OP; sampled 0 -> IDLE with counter 0.
- OP: capture 2 bits. 10 = read, 01 = write. 00 or 11 -> IDLE with counter 0.
- PHYAD: capture 5 bits, MSB first.
- REGAD: capture 5 bits.
  - PHYAD != PHYADDR -> SKIP; mdio_oe never asserts for a mismatched frame.
  - On match, a read latches the read data on the same clk as the final REGAD sample. Unimplemented addresses return 16'h0000.
- SKIP: ignore 18 sampled bits (TA + data), then go to IDLE with counter 0.
- TA (write): consume 2 sampled bits; values are not checked.
- TA (read):
  - Bit 1: mdio_oe stays 0.
  - On the fall following the first TA rise: mdio_oe=1, mdio_o=0.
- RDATA:
  - On each subsequent fall, drive the next data bit, MSB first, 16 bits.
  - On the fall after the D0 rise: mdio_oe=0, go to IDLE with counter 0.
- WDATA:
  - Shift 16 sampled bits.
  - On the clk after the 16th rise: if addr < NREG, update the register; in all cases set wr_addr/wr_data and pulse wr_strobe for exactly 1 clk.
  - Unimplemented-address writes are discarded but still strobed.
  - Go to IDLE with counter 0.
- Host writes: host_we updates host_addr (if < NREG) in the next clk.
  - If an MDIO write commits in the same clk, the MDIO write wins and the host write is dropped.
  - A host write to the register currently being read does not alter the already-latched read data.
- Mid-operation reset: rst during any state returns everything to reset values in the next clk. mdio_oe drops immediately; no partial write commits.
- Latency:
  - MDC rise to internal sample: 3 clk.
  - MDC fall to mdio_o change: 3 clk.

Optional Feature:
- MDIO_PREAMBLE_SUPPRESSION_EN defined:
  - After a completed frame addressed to PHYADDR, the next frame is accepted with preamble length >= 1 (a single idle 1 then ST=01).
  - Any failed or mismatched frame re-arms the full PRE_LEN requirement.
- Undefined: PRE_LEN ones are always required.

Test Plan:
- Full frame with reset values: 32 ones, ST=01, OP=01, PHYAD=1, REGAD=4, TA=10, data 16'hA5C3 -> wr_strobe 1 clk, wr_addr=4, wr_data=16'hA5C3. A following read of REGAD=4 returns 16'hA5C3 MSB first, with mdio_oe high from TA bit 2 through D0.
- Read of reg 2 after reset -> 16'h0022. Read of REGAD=20 (NREG=16) -> 16'h0000.
- Frame with PHYAD=7 -> mdio_oe stays 0 for the whole frame. No wr_strobe. A next valid frame addressed to PHYAD=1 works.
- Only 31 preamble ones before ST -> frame ignored, no strobe or drive. With MDIO_PREAMBLE_SUPPRESSION_EN: a back-to-back read after a valid frame with a 1-bit preamble -> answered.
- host_we reg5=16'h1234 in the same clk as an MDIO write commit to reg5=16'hBEEF -> reg5=16'hBEEF. A separate host write of 16'h1234 -> read returns 16'h1234.
- rst asserted mid-RDATA (after 8 bits) -> mdio_oe=0 next clk; reg2/3 restored to ID1/ID2; a subsequent full frame is decoded correctly.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side) answering reads/writes from a local 16-bit register file.
// Optional build macro MDIO_PREAMBLE_SUPPRESSION_EN: short preamble accepted after a completed frame.
module mdio_responder #(
   parameter logic [4:0]  PHYADDR = 5'd1,
   parameter int          NREG    = 16,
   parameter logic [15:0] ID1     = 16'h0022,
   parameter logic [15:0] ID2     = 16'h1560,
   parameter int          PRE_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        host_we,
   input  logic [4:0]  host_addr,
   input  logic [15:0] host_data,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data
);

   localparam int PRE_W = $clog2(PRE_LEN + 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_LEN);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
   localparam bit SUPPRESS_EN = 1'b1;
`else
   localparam bit SUPPRESS_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD,
      S_SKIP, S_TA_W, S_TA_R, S_RDATA, S_WDATA
   } state_t;

   state_t            state_q, state_d;
   logic              mdc_m_q, mdc_s_q, mdc_d_q;
   logic              mdio_m_q, mdio_s_q;
   logic [4:0]        cnt_q, cnt_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              armed_q, armed_d;
   logic              op_q, op_d;
   logic              rd_q, rd_d;
   logic [4:0]        phy_q, phy_d;
   logic [4:0]        regad_q, regad_d;
   logic [15:0]       shift_q, shift_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              oe_q, oe_d;
   logic              out_q, out_d;
   logic              wr_strobe_q, wr_strobe_d;
   logic [4:0]        wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [15:0]       regs_q [NREG];

   logic              rise, fall, commit, pre_ok;
   logic [4:0]        regad_nxt;
   logic [15:0]       shift_nxt;
   logic [15:0]       rd_lookup;

   assign rise      = mdc_s_q & ~mdc_d_q;
   assign fall      = ~mdc_s_q & mdc_d_q;
   assign regad_nxt = {regad_q[3:0], mdio_s_q};
   assign shift_nxt = {shift_q[14:0], mdio_s_q};
   // Once armed by a completed frame, any nonzero run of ones counts as preamble.
   assign pre_ok    = (pre_q == PRE_MAX) || (SUPPRESS_EN && armed_q && (pre_q != '0));

   always_comb begin
      rd_lookup = 16'h0000;
      for (int i = 0; i < NREG; i++) begin
         if (regad_nxt == 5'(i)) rd_lookup = regs_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_m_q  <= 1'b0;
         mdc_s_q  <= 1'b0;
         mdc_d_q  <= 1'b0;
         mdio_m_q <= 1'b0;
         mdio_s_q <= 1'b0;
      end else begin
         mdc_m_q  <= mdc;
         mdc_s_q  <= mdc_m_q;
         mdc_d_q  <= mdc_s_q;
         mdio_m_q <= mdio_i;
         mdio_s_q <= mdio_m_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pre_q       <= '0;
         armed_q     <= 1'b0;
         op_q        <= 1'b0;
         rd_q        <= 1'b0;
         phy_q       <= '0;
         regad_q     <= '0;
         shift_q     <= '0;
         rdata_q     <= '0;
         oe_q        <= 1'b0;
         out_q       <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         armed_q     <= armed_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         phy_q       <= phy_d;
         regad_q     <= regad_d;
         shift_q     <= shift_d;
         rdata_q     <= rdata_d;
         oe_q        <= oe_d;
         out_q       <= out_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // An MDIO commit in the same clk suppresses any host write, whatever its address.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == 2) ? ID1 : ((i == 3) ? ID2 : 16'h0000);
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (commit && (regad_q == 5'(i))) begin
               regs_q[i] <= shift_nxt;
            end else if (!commit && host_we && (host_addr == 5'(i))) begin
               regs_q[i] <= host_data;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pre_d       = pre_q;
      armed_d     = armed_q;
      op_d        = op_q;
      rd_d        = rd_q;
      phy_d       = phy_q;
      regad_d     = regad_q;
      shift_d     = shift_q;
      rdata_d     = rdata_q;
      oe_d        = oe_q;
      out_d       = out_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      commit      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               if (mdio_s_q) begin
                  if (pre_q != PRE_MAX) pre_d = pre_q + PRE_ONE;
               end else if (pre_ok) begin
                  state_d = S_ST2;
                  armed_d = 1'b0;
               end else begin
                  pre_d   = '0;
                  armed_d = 1'b0;
               end
            end
         end
         S_ST2: begin
            if (rise) begin
               cnt_d = '0;
               if (mdio_s_q) begin
                  state_d = S_OP;
               end else begin
                  state_d = S_IDLE;
                  pre_d   = '0;
               end
            end
         end
         S_OP: begin
            if (rise) begin
               if (cnt_q == 5'd0) begin
                  op_d  = mdio_s_q;
                  cnt_d = 5'd1;
               end else begin
                  cnt_d = '0;
                  if (op_q != mdio_s_q) begin
                     state_d = S_PHYAD;
                     rd_d    = op_q;
                  end else begin
                     state_d = S_IDLE;
                     pre_d   = '0;
                  end
               end
            end
         end
         S_PHYAD: begin
            if (rise) begin
               phy_d = {phy_q[3:0], mdio_s_q};
               if (cnt_q == 5'd4) begin
                  cnt_d   = '0;
                  state_d = S_REGAD;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_REGAD: begin
            if (rise) begin
               regad_d = regad_nxt;
               if (cnt_q == 5'd4) begin
                  cnt_d = '0;
                  if (phy_q != PHYADDR) begin
                     state_d = S_SKIP;
                  end else if (rd_q) begin
                     rdata_d = rd_lookup;
                     state_d = S_TA_R;
                  end else begin
                     state_d = S_TA_W;
                  end
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_SKIP: begin
            if (rise) begin
               if (cnt_q == 5'd17) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  pre_d   = '0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_TA_W: begin
            if (rise) begin
               if (cnt_q == 5'd1) begin
                  cnt_d   = '0;
                  state_d = S_WDATA;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         // The fall of the last REGAD bit arrives first; only the fall after the TA1 rise starts driving.
         S_TA_R: begin
            if (rise) begin
               cnt_d = 5'd1;
            end else if (fall && (cnt_q == 5'd1)) begin
               oe_d    = 1'b1;
               out_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            if (fall) begin
               if (cnt_q == 5'd16) begin
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  pre_d   = '0;
                  armed_d = SUPPRESS_EN;
               end else begin
                  out_d   = rdata_q[15];
                  rdata_d = {rdata_q[14:0], 1'b0};
                  cnt_d   = cnt_q + 5'd1;
               end
            end
         end
         S_WDATA: begin
            if (rise) begin
               shift_d = shift_nxt;
               if (cnt_q == 5'd15) begin
                  commit      = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = regad_q;
                  wr_data_d   = shift_nxt;
                  cnt_d       = '0;
                  state_d     = S_IDLE;
                  pre_d       = '0;
                  armed_d     = SUPPRESS_EN;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
            oe_d    = 1'b0;
         end
      endcase
   end

   assign mdio_o    = out_q;
   assign mdio_oe   = oe_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
